// File: rtl/readout_ctrl_pkg.sv
// Shared types, default widths and word packing for the readout sequencer.
package readout_ctrl_pkg;

   localparam int unsigned DefAddrWidth = 6;
   localparam int unsigned DefDataWidth = 21;
   localparam int unsigned DefBcidWidth = 6;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StRead,
      StOut,
      StDone
   } readout_state_t;

   // Packs {ts, addr, data} LSB-aligned; the caller keeps the low word bits.
   function automatic logic [127:0] pack_word(input logic [63:0] ts,
                                              input logic [63:0] addr,
                                              input logic [63:0] data,
                                              input int unsigned addr_width,
                                              input int unsigned data_width);
      pack_word = (128'(ts) << (addr_width + data_width)) | (128'(addr) << data_width)
                | 128'(data);
   endfunction

endpackage

// File: rtl/readout_bcid_cnt.sv
// Free-running wrapping timestamp counter with synchronous active-low reset.
module readout_bcid_cnt #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/readout_ctrl.sv
// End-of-column token-chain readout sequencer: freeze, read each hit, emit {ts, addr, data}.
// Optional hit-limit watchdog enabled by defining READOUT_CTRL_WATCHDOG_EN.
module readout_ctrl
   import readout_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = DefAddrWidth,
   parameter int unsigned DATA_WIDTH    = DefDataWidth,
   parameter int unsigned BCID_WIDTH    = DefBcidWidth,
   parameter int unsigned READ_CYCLES   = 2,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned MAX_READS     = 64
) (
   input  logic                                     Clk,
   input  logic                                     Rst_n,
   input  logic                                     Enable,
   input  logic                                     Token,
   input  logic [ADDR_WIDTH-1:0]                    ColAddr,
   input  logic [DATA_WIDTH-1:0]                    ColData,
   output logic                                     Read,
   output logic                                     Freeze,
   output logic [BCID_WIDTH-1:0]                    Bcid,
   output logic [BCID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] OutData,
   output logic                                     OutValid,
   input  logic                                     OutReady,
   output logic                                     Busy,
   output logic                                     Error
);

   localparam int unsigned WordWidth = BCID_WIDTH + ADDR_WIDTH + DATA_WIDTH;
   localparam int unsigned CntMax    = (SETTLE_CYCLES > READ_CYCLES) ? SETTLE_CYCLES
                                                                     : READ_CYCLES;
   localparam int unsigned CntWidth  = $clog2(CntMax + 1);

   readout_state_t          state_q, state_d;
   logic [CntWidth-1:0]     cnt_q, cnt_d;
   logic                    token_q;
   logic                    freeze_q, freeze_d;
   logic [BCID_WIDTH-1:0]   ts_q, ts_d;
   logic [WordWidth-1:0]    data_q, data_d;
   logic [127:0]            packed_word;
   logic                    unused_word_hi;

   readout_bcid_cnt #(
      .WIDTH(BCID_WIDTH)
   ) u_bcid_cnt (
      .clk  (Clk),
      .rst_n(Rst_n),
      .count(Bcid)
   );

   assign packed_word    = pack_word(64'(ts_q), 64'(ColAddr), 64'(ColData), ADDR_WIDTH,
                                     DATA_WIDTH);
   assign unused_word_hi = ^packed_word[127:WordWidth];

`ifdef READOUT_CTRL_WATCHDOG_EN
   localparam int unsigned WdWidth = $clog2(MAX_READS + 1);
   logic [WdWidth-1:0] wd_q, wd_d;
   logic               error_q, error_d;
   assign Error = error_q;
`else
   logic unused_max_reads;
   assign unused_max_reads = ^MAX_READS;
   assign Error = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         token_q  <= 1'b0;
         freeze_q <= 1'b0;
         ts_q     <= '0;
         data_q   <= '0;
`ifdef READOUT_CTRL_WATCHDOG_EN
         wd_q     <= '0;
         error_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         token_q  <= Token;
         freeze_q <= freeze_d;
         ts_q     <= ts_d;
         data_q   <= data_d;
`ifdef READOUT_CTRL_WATCHDOG_EN
         wd_q     <= wd_d;
         error_q  <= error_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      freeze_d = freeze_q;
      ts_d     = ts_q;
      data_d   = data_q;
`ifdef READOUT_CTRL_WATCHDOG_EN
      wd_d     = wd_q;
      error_d  = error_q;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef READOUT_CTRL_WATCHDOG_EN
            wd_d = '0;
`endif
            cnt_d = '0;
            if (Enable && token_q) begin
               state_d  = StSettle;
               freeze_d = 1'b1;
               ts_d     = Bcid;
            end
         end
         StSettle: begin
            if (cnt_q == CntWidth'(SETTLE_CYCLES - 1)) begin
               cnt_d = '0;
               if (!token_q) begin
                  state_d = StDone;
               end else begin
`ifdef READOUT_CTRL_WATCHDOG_EN
                  if (wd_q == WdWidth'(MAX_READS)) begin
                     state_d = StDone;
                     error_d = 1'b1;
                  end else begin
                     state_d = StRead;
                     wd_d    = wd_q + WdWidth'(1);
                  end
`else
                  state_d = StRead;
`endif
               end
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end
         StRead: begin
            // Sample the bus on the last Read-high cycle so the columns have settled.
            if (cnt_q == CntWidth'(READ_CYCLES - 1)) begin
               cnt_d   = '0;
               data_d  = packed_word[WordWidth-1:0];
               state_d = StOut;
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end
         StOut: begin
            if (OutReady) begin
               state_d = StSettle;
            end
         end
         StDone: begin
            freeze_d = 1'b0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign Read     = (state_q == StRead);
   assign OutValid = (state_q == StOut);
   assign Busy     = (state_q != StIdle);
   assign Freeze   = freeze_q;
   assign OutData  = data_q;

endmodule

// File: tb/tb_readout_ctrl.sv
// Directed self-checking bench for readout_ctrl at default widths, MAX_READS=3.
module tb_readout_ctrl;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 21;
   localparam int unsigned BW = 6;
   localparam int unsigned WW = AW + DW + BW;

   logic          Clk;
   logic          Rst_n;
   logic          Enable;
   logic          Token;
   logic [AW-1:0] ColAddr;
   logic [DW-1:0] ColData;
   logic          Read;
   logic          Freeze;
   logic [BW-1:0] Bcid;
   logic [WW-1:0] OutData;
   logic          OutValid;
   logic          OutReady;
   logic          Busy;
   logic          Error;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int words    = 0;
   int read_rises = 0;
   int last_rise_cyc = 0;
   int prev_rise_cyc = 0;
   logic read_prev = 1'b0;
   logic [WW-1:0] last_word = '0;

   readout_ctrl #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .BCID_WIDTH   (BW),
      .READ_CYCLES  (2),
      .SETTLE_CYCLES(1),
      .MAX_READS    (3)
   ) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Enable  (Enable),
      .Token   (Token),
      .ColAddr (ColAddr),
      .ColData (ColData),
      .Read    (Read),
      .Freeze  (Freeze),
      .Bcid    (Bcid),
      .OutData (OutData),
      .OutValid(OutValid),
      .OutReady(OutReady),
      .Busy    (Busy),
      .Error   (Error)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Mid-cycle observer: handshake words and Read rising edges.
   always @(negedge Clk) begin
      cyc = cyc + 1;
      if (Rst_n && OutValid && OutReady) begin
         words = words + 1;
         last_word = OutData;
      end
      if (Read === 1'b1 && read_prev !== 1'b1) begin
         read_rises = read_rises + 1;
         prev_rise_cyc = last_rise_cyc;
         last_rise_cyc = cyc;
      end
      read_prev = Read;
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic wait_bcid(input logic [BW-1:0] target);
      int k;
      k = 0;
      while (Bcid !== target && k < 200) begin
         tick();
         k++;
      end
      n_checks++;
      if (Bcid !== target) $display("FAIL wait_bcid: got %0d want %0d", Bcid, target);
      else n_pass++;
   endtask

   task automatic test_reset();
      tick(2);
      n_checks++; if (Read !== 1'b0) $display("FAIL rst_read: got %b want 0", Read); else n_pass++;
      n_checks++; if (Freeze !== 1'b0) $display("FAIL rst_freeze: got %b want 0", Freeze); else n_pass++;
      n_checks++; if (OutValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", OutValid); else n_pass++;
      n_checks++; if (Bcid !== 6'd0) $display("FAIL rst_bcid: got %0d want 0", Bcid); else n_pass++;
      n_checks++; if (OutData !== 33'd0) $display("FAIL rst_data: got %h want 0", OutData); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", Busy); else n_pass++;
      n_checks++; if (Error !== 1'b0) $display("FAIL rst_error: got %b want 0", Error); else n_pass++;
      Rst_n = 1'b1;
      tick();
      n_checks++; if (Bcid !== 6'd1) $display("FAIL bcid_inc1: got %0d want 1", Bcid); else n_pass++;
      tick();
      n_checks++; if (Bcid !== 6'd2) $display("FAIL bcid_inc2: got %0d want 2", Bcid); else n_pass++;
   endtask

   task automatic test_enable_gate();
      Enable = 1'b0;
      Token  = 1'b1;
      tick(10);
      n_checks++; if (Busy !== 1'b0) $display("FAIL en_gate_busy: got %b want 0", Busy); else n_pass++;
      n_checks++; if (Freeze !== 1'b0) $display("FAIL en_gate_freeze: got %b want 0", Freeze); else n_pass++;
      Token = 1'b0;
      tick(3);
      Enable = 1'b1;
   endtask

   task automatic test_single_hit();
      logic [WW-1:0] exp;
      int w0;
      exp = {6'd11, 6'd5, 21'h1ABCD};
      wait_bcid(6'd10);
      w0 = words;
      Token = 1'b1; ColAddr = 6'd5; ColData = 21'h1ABCD;
      tick();
      n_checks++; if (Freeze !== 1'b0) $display("FAIL single_freeze_k1: got %b want 0", Freeze); else n_pass++;
      tick();
      n_checks++; if (Freeze !== 1'b1) $display("FAIL single_freeze_k2: got %b want 1", Freeze); else n_pass++;
      n_checks++; if (Busy !== 1'b1) $display("FAIL single_busy_k2: got %b want 1", Busy); else n_pass++;
      n_checks++; if (Read !== 1'b0) $display("FAIL single_read_k2: got %b want 0", Read); else n_pass++;
      tick();
      n_checks++; if (Read !== 1'b1) $display("FAIL single_read_k3: got %b want 1", Read); else n_pass++;
      tick();
      n_checks++; if (Read !== 1'b1) $display("FAIL single_read_k4: got %b want 1", Read); else n_pass++;
      n_checks++; if (OutValid !== 1'b0) $display("FAIL single_valid_k4: got %b want 0", OutValid); else n_pass++;
      tick();
      n_checks++; if (Read !== 1'b0) $display("FAIL single_read_k5: got %b want 0", Read); else n_pass++;
      n_checks++; if (OutValid !== 1'b1) $display("FAIL single_valid_k5: got %b want 1", OutValid); else n_pass++;
      n_checks++; if (OutData !== exp) $display("FAIL single_data: got %h want %h", OutData, exp); else n_pass++;
      Token = 1'b0;
      tick(2);
      n_checks++; if (Freeze !== 1'b1) $display("FAIL single_freeze_h1: got %b want 1", Freeze); else n_pass++;
      tick();
      n_checks++; if (Freeze !== 1'b0) $display("FAIL single_freeze_h2: got %b want 0", Freeze); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", Busy); else n_pass++;
      n_checks++; if (words - w0 !== 1) $display("FAIL single_words: got %0d want 1", words - w0); else n_pass++;
      n_checks++; if (last_word !== exp) $display("FAIL single_word: got %h want %h", last_word, exp); else n_pass++;
   endtask

   task automatic test_two_hits();
      logic [WW-1:0] exp1, exp2;
      int w0, r0;
      exp1 = {6'd21, 6'd3, 21'h00033};
      exp2 = {6'd21, 6'd7, 21'h00077};
      wait_bcid(6'd20);
      w0 = words; r0 = read_rises;
      Token = 1'b1; ColAddr = 6'd3; ColData = 21'h00033;
      tick(3);
      n_checks++; if (Read !== 1'b1) $display("FAIL two_read1: got %b want 1", Read); else n_pass++;
      tick(2);
      n_checks++; if (OutData !== exp1) $display("FAIL two_data1: got %h want %h", OutData, exp1); else n_pass++;
      ColAddr = 6'd7; ColData = 21'h00077;
      tick();
      n_checks++; if (Read !== 1'b0) $display("FAIL two_read_gap: got %b want 0", Read); else n_pass++;
      tick();
      n_checks++; if (Read !== 1'b1) $display("FAIL two_read2: got %b want 1", Read); else n_pass++;
      tick(2);
      n_checks++; if (OutValid !== 1'b1) $display("FAIL two_valid2: got %b want 1", OutValid); else n_pass++;
      n_checks++; if (OutData !== exp2) $display("FAIL two_data2: got %h want %h", OutData, exp2); else n_pass++;
      Token = 1'b0;
      tick(3);
      n_checks++; if (Busy !== 1'b0) $display("FAIL two_busy_end: got %b want 0", Busy); else n_pass++;
      n_checks++; if (words - w0 !== 2) $display("FAIL two_words: got %0d want 2", words - w0); else n_pass++;
      n_checks++; if (read_rises - r0 !== 2) $display("FAIL two_reads: got %0d want 2", read_rises - r0); else n_pass++;
      n_checks++;
      if (last_rise_cyc - prev_rise_cyc !== 4)
         $display("FAIL two_read_period: got %0d want 4", last_rise_cyc - prev_rise_cyc);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [WW-1:0] exp;
      int w0, r0;
      exp = {6'd31, 6'd9, 21'h15555};
      wait_bcid(6'd30);
      w0 = words; r0 = read_rises;
      OutReady = 1'b0;
      Token = 1'b1; ColAddr = 6'd9; ColData = 21'h15555;
      tick(5);
      n_checks++; if (OutValid !== 1'b1) $display("FAIL bp_valid0: got %b want 1", OutValid); else n_pass++;
      Token = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++; if (OutValid !== 1'b1) $display("FAIL bp_valid: got %b want 1", OutValid); else n_pass++;
         n_checks++; if (OutData !== exp) $display("FAIL bp_data: got %h want %h", OutData, exp); else n_pass++;
         n_checks++; if (Read !== 1'b0) $display("FAIL bp_read: got %b want 0", Read); else n_pass++;
      end
      OutReady = 1'b1;
      tick(3);
      n_checks++; if (Busy !== 1'b0) $display("FAIL bp_busy_end: got %b want 0", Busy); else n_pass++;
      n_checks++; if (words - w0 !== 1) $display("FAIL bp_words: got %0d want 1", words - w0); else n_pass++;
      n_checks++; if (read_rises - r0 !== 1) $display("FAIL bp_reads: got %0d want 1", read_rises - r0); else n_pass++;
   endtask

   task automatic test_bcid_wrap();
      logic [WW-1:0] exp;
      exp = {6'd63, 6'd1, 21'd2};
      wait_bcid(6'd62);
      Token = 1'b1; ColAddr = 6'd1; ColData = 21'd2;
      tick();
      n_checks++; if (Bcid !== 6'd63) $display("FAIL wrap_bcid63: got %0d want 63", Bcid); else n_pass++;
      tick();
      n_checks++; if (Bcid !== 6'd0) $display("FAIL wrap_bcid0: got %0d want 0", Bcid); else n_pass++;
      n_checks++; if (Freeze !== 1'b1) $display("FAIL wrap_freeze: got %b want 1", Freeze); else n_pass++;
      tick(3);
      n_checks++; if (OutValid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", OutValid); else n_pass++;
      n_checks++; if (OutData !== exp) $display("FAIL wrap_data: got %h want %h", OutData, exp); else n_pass++;
      Token = 1'b0;
      tick(3);
      n_checks++; if (Busy !== 1'b0) $display("FAIL wrap_busy_end: got %b want 0", Busy); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      int w0;
      wait_bcid(6'd40);
      w0 = words;
      Token = 1'b1; ColAddr = 6'd4; ColData = 21'h00004;
      tick(4);
      n_checks++; if (Read !== 1'b1) $display("FAIL rmr_read2: got %b want 1", Read); else n_pass++;
      Rst_n = 1'b0; Token = 1'b0;
      tick();
      n_checks++; if (Read !== 1'b0) $display("FAIL rmr_read: got %b want 0", Read); else n_pass++;
      n_checks++; if (Freeze !== 1'b0) $display("FAIL rmr_freeze: got %b want 0", Freeze); else n_pass++;
      n_checks++; if (OutValid !== 1'b0) $display("FAIL rmr_valid: got %b want 0", OutValid); else n_pass++;
      n_checks++; if (Bcid !== 6'd0) $display("FAIL rmr_bcid: got %0d want 0", Bcid); else n_pass++;
      n_checks++; if (OutData !== 33'd0) $display("FAIL rmr_data: got %h want 0", OutData); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL rmr_busy: got %b want 0", Busy); else n_pass++;
      n_checks++; if (Error !== 1'b0) $display("FAIL rmr_error: got %b want 0", Error); else n_pass++;
      Rst_n = 1'b1;
      tick(8);
      n_checks++; if (Busy !== 1'b0) $display("FAIL rmr_idle: got %b want 0", Busy); else n_pass++;
      n_checks++; if (words - w0 !== 0) $display("FAIL rmr_words: got %0d want 0", words - w0); else n_pass++;
   endtask

   task automatic test_watchdog();
      int w0, k;
      wait_bcid(6'd10);
      w0 = words;
      Token = 1'b1; ColAddr = 6'd2; ColData = 21'h00222;
      k = 0;
      while (words - w0 < 1 && k < 20) begin tick(); k++; end
      n_checks++; if (words - w0 < 1) $display("FAIL wd_first_word: got %0d want 1", words - w0); else n_pass++;
      Enable = 1'b0;
`ifdef READOUT_CTRL_WATCHDOG_EN
      k = 0;
      while (Busy !== 1'b0 && k < 60) begin tick(); k++; end
      n_checks++; if (Busy !== 1'b0) $display("FAIL wd_done: got %b want 0", Busy); else n_pass++;
      n_checks++; if (words - w0 !== 3) $display("FAIL wd_words: got %0d want 3", words - w0); else n_pass++;
      n_checks++; if (Freeze !== 1'b0) $display("FAIL wd_freeze: got %b want 0", Freeze); else n_pass++;
      n_checks++; if (Error !== 1'b1) $display("FAIL wd_error: got %b want 1", Error); else n_pass++;
      tick(5);
      n_checks++; if (Busy !== 1'b0) $display("FAIL wd_stay_idle: got %b want 0", Busy); else n_pass++;
      Token = 1'b0;
      tick(3);
`else
      k = 0;
      while (words - w0 < 5 && k < 60) begin tick(); k++; end
      n_checks++; if (words - w0 < 5) $display("FAIL nowd_words: got %0d want 5", words - w0); else n_pass++;
      n_checks++; if (Error !== 1'b0) $display("FAIL nowd_error: got %b want 0", Error); else n_pass++;
      n_checks++; if (Freeze !== 1'b1) $display("FAIL nowd_freeze: got %b want 1", Freeze); else n_pass++;
      Token = 1'b0;
      k = 0;
      while (Busy !== 1'b0 && k < 20) begin tick(); k++; end
      n_checks++; if (Busy !== 1'b0) $display("FAIL nowd_end: got %b want 0", Busy); else n_pass++;
      tick(3);
      n_checks++; if (Busy !== 1'b0) $display("FAIL nowd_enable_off: got %b want 0", Busy); else n_pass++;
`endif
      Enable = 1'b1;
   endtask

   initial begin
      Rst_n = 1'b0; Enable = 1'b1; Token = 1'b0; OutReady = 1'b1;
      ColAddr = '0; ColData = '0;
      test_reset();
      test_enable_gate();
      test_single_hit();
      test_two_hits();
      test_backpressure();
      test_bcid_wrap();
      test_reset_mid_read();
      test_watchdog();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
